// File: rtl/rcu_pkg.sv
// Shared RCU definitions: domain indices, sequencer states, reset-cause codes
// and the domain release order.
package rcu_pkg;

  localparam int RCU_TEST_CLK       = 0;
  localparam int RCU_BYPASS_CLK     = 1;
  localparam int RCU_CORE_CLK       = 2;
  localparam int RCU_LF_PERI_CLK    = 3;
  localparam int RCU_HF_PERI_CLK    = 4;
  localparam int RCU_AUD_CLK        = 5;
  localparam int RCU_RTC_CLK        = 6;
  localparam int RCU_CLK_MODE_WIDTH = 7;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    PLL_WAIT = 2'd1,
    RELEASE  = 2'd2,
    RUN      = 2'd3
  } rcu_state_e;

  localparam logic [1:0] RCU_CAUSE_POR = 2'b00;
  localparam logic [1:0] RCU_CAUSE_EXT = 2'b01;
  localparam logic [1:0] RCU_CAUSE_WDT = 2'b10;
  localparam logic [1:0] RCU_CAUSE_PLL = 2'b11;

  // Release order table: always-on RTC first, core domain last.
  function automatic logic [2:0] rcu_order(input logic [2:0] idx);
    logic [2:0] dom;
    dom = 3'(RCU_CORE_CLK);
    case (idx)
      3'd0: dom = 3'(RCU_RTC_CLK);
      3'd1: dom = 3'(RCU_LF_PERI_CLK);
      3'd2: dom = 3'(RCU_HF_PERI_CLK);
      3'd3: dom = 3'(RCU_AUD_CLK);
      3'd4: dom = 3'(RCU_TEST_CLK);
      3'd5: dom = 3'(RCU_BYPASS_CLK);
      default: dom = 3'(RCU_CORE_CLK);
    endcase
    return dom;
  endfunction

endpackage

// File: rtl/rcu_lock_filt.sv
// PLL lock qualifier: lock_ok_o when lock is seen high on two consecutive
// samples, lock_lost_o when seen low on two consecutive samples.
module rcu_lock_filt (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic lock_i,
  output logic lock_ok_o,
  output logic lock_lost_o
);

  logic hi_q;
  logic lo_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      hi_q <= 1'b0;
      lo_q <= 1'b0;
    end else begin
      hi_q <= lock_i;
      lo_q <= ~lock_i;
    end
  end

  assign lock_ok_o   = hi_q & lock_i;
  assign lock_lost_o = lo_q & ~lock_i;

endmodule

// File: rtl/rcu_rst_seq.sv
// RCU reset sequencer: holds all domain resets while any source is active,
// optionally waits for PLL lock, then releases domains one by one.
module rcu_rst_seq
  import rcu_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8,
  parameter int PLL_TIMEOUT = 1024,
  parameter int NUM_DOM     = RCU_CLK_MODE_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               ext_rst_n_i,
  input  logic               wdt_rst_n_i,
  input  logic               pll_en_i,
  input  logic               pll_lock_i,
  output logic [NUM_DOM-1:0] rst_n_o,
  output logic               pll_strb_o,
  output logic               pll_to_o,
  output logic               busy_o,
  output logic [1:0]         rst_cause_o,
  output rcu_state_e         dbg_state_o
);

  localparam int CNT_MAX =
    (HOLD_CYCLES > STEP_CYCLES)
      ? ((HOLD_CYCLES > PLL_TIMEOUT) ? HOLD_CYCLES : PLL_TIMEOUT)
      : ((STEP_CYCLES > PLL_TIMEOUT) ? STEP_CYCLES : PLL_TIMEOUT);
  localparam int CW = $clog2(CNT_MAX);
  localparam int IW = $clog2(NUM_DOM);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(PLL_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOM - 1);

  rcu_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic          src_ok_q;
  logic          src_ok;
  logic          lock_ok;
  logic          lock_lost;

  assign src_ok      = ext_rst_n_i & wdt_rst_n_i;
  assign dbg_state_o = state_q;

  // Filter history is discarded whenever the sequence is held.
  rcu_lock_filt u_lock_filt (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clr_i       (state_q == HOLD),
    .lock_i      (pll_lock_i),
    .lock_ok_o   (lock_ok),
    .lock_lost_o (lock_lost)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      src_ok_q    <= 1'b0;
      rst_n_o     <= '0;
      pll_strb_o  <= 1'b0;
      pll_to_o    <= 1'b0;
      busy_o      <= 1'b1;
      rst_cause_o <= RCU_CAUSE_POR;
    end else begin
      src_ok_q <= src_ok;
      if (!src_ok) begin
        state_q    <= HOLD;
        cnt_q      <= '0;
        idx_q      <= '0;
        rst_n_o    <= '0;
        pll_strb_o <= 1'b0;
        busy_o     <= 1'b1;
        // A source held low across HOLD keeps the cause it was first given.
        if (state_q != HOLD || src_ok_q)
          rst_cause_o <= !ext_rst_n_i ? RCU_CAUSE_EXT : RCU_CAUSE_WDT;
      end else begin
        case (state_q)
          HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              cnt_q   <= '0;
              state_q <= pll_en_i ? PLL_WAIT : RELEASE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PLL_WAIT: begin
            if (lock_ok) begin
              cnt_q      <= '0;
              state_q    <= RELEASE;
              pll_strb_o <= 1'b1;
              pll_to_o   <= 1'b0;
            end else if (cnt_q == TO_LAST) begin
              cnt_q    <= '0;
              state_q  <= RELEASE;
              pll_to_o <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RELEASE: begin
            if (cnt_q == STEP_LAST) begin
              cnt_q <= '0;
              rst_n_o[rcu_order(3'(idx_q))] <= 1'b1;
              if (idx_q == IDX_LAST) begin
                idx_q   <= '0;
                state_q <= RUN;
                busy_o  <= 1'b0;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RUN: begin
            // Loss only matters when the PLL is actually clocking the domains.
            if (pll_strb_o && lock_lost) begin
              state_q     <= HOLD;
              cnt_q       <= '0;
              idx_q       <= '0;
              rst_n_o     <= '0;
              pll_strb_o  <= 1'b0;
              busy_o      <= 1'b1;
              rst_cause_o <= RCU_CAUSE_PLL;
            end
          end
          default: state_q <= HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rcu_rst_seq.sv
// Directed bench for rcu_rst_seq: POR sequencing, PLL lock/timeout, PLL loss,
// watchdog and external reset interruptions.
module tb_rcu_rst_seq;
  import rcu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       ext_rst_n_i;
  logic       wdt_rst_n_i;
  logic       pll_en_i;
  logic       pll_lock_i;
  logic [6:0] rst_n_o;
  logic       pll_strb_o;
  logic       pll_to_o;
  logic       busy_o;
  logic [1:0] rst_cause_o;
  rcu_state_e dbg_state_o;

  int total = 0;
  int bad   = 0;

  // Clock / reset
  always #5 clk = ~clk;

  rcu_rst_seq dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .ext_rst_n_i (ext_rst_n_i),
    .wdt_rst_n_i (wdt_rst_n_i),
    .pll_en_i    (pll_en_i),
    .pll_lock_i  (pll_lock_i),
    .rst_n_o     (rst_n_o),
    .pll_strb_o  (pll_strb_o),
    .pll_to_o    (pll_to_o),
    .busy_o      (busy_o),
    .rst_cause_o (rst_cause_o),
    .dbg_state_o (dbg_state_o)
  );

  // Expected domain mask k edges into a sequence whose first release lands on
  // edge 'first'; releases follow RTC, LF_PERI, HF_PERI, AUD, TEST, BYPASS, CORE.
  function automatic logic [6:0] exp_mask(input int k, input int first);
    int ord [7] = '{6, 3, 4, 5, 0, 1, 2};
    logic [6:0] m;
    m = '0;
    for (int j = 0; j < 7; j++)
      if (k >= first + 8 * j) m[ord[j]] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n_i = 1'b0;
    repeat (2) tick();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; ext_rst_n_i = 1'b1; wdt_rst_n_i = 1'b1;
    pll_en_i = 1'b0; pll_lock_i = 1'b0;
    repeat (3) tick();
    total++; if (rst_n_o !== 7'h00) begin bad++; $display("FAIL reset_mask got=%b exp=%b", rst_n_o, 7'h00); end
    total++; if (pll_strb_o !== 1'b0) begin bad++; $display("FAIL reset_strb got=%b exp=0", pll_strb_o); end
    total++; if (pll_to_o !== 1'b0) begin bad++; $display("FAIL reset_to got=%b exp=0", pll_to_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy_o); end
    total++; if (rst_cause_o !== 2'b00) begin bad++; $display("FAIL reset_cause got=%b exp=00", rst_cause_o); end
    total++; if (dbg_state_o !== HOLD) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state_o, HOLD); end
  endtask

  task automatic test_por_bypass();
    pll_en_i = 1'b0;
    rst_n_i  = 1'b1;
    for (int k = 1; k <= 76; k++) begin
      tick();
      total++; if (rst_n_o !== exp_mask(k, 24)) begin bad++; $display("FAIL por_mask k=%0d got=%b exp=%b", k, rst_n_o, exp_mask(k, 24)); end
      total++; if (busy_o !== (k < 72)) begin bad++; $display("FAIL por_busy k=%0d got=%b exp=%b", k, busy_o, (k < 72)); end
    end
    total++; if (pll_strb_o !== 1'b0) begin bad++; $display("FAIL por_strb got=%b exp=0", pll_strb_o); end
    total++; if (rst_cause_o !== 2'b00) begin bad++; $display("FAIL por_cause got=%b exp=00", rst_cause_o); end
    total++; if (dbg_state_o !== RUN) begin bad++; $display("FAIL por_state got=%0d exp=%0d", dbg_state_o, RUN); end
  endtask

  task automatic test_pll_timeout();
    pll_en_i = 1'b1; pll_lock_i = 1'b0;
    apply_reset();
    for (int k = 1; k <= 1100; k++) begin
      tick();
      total++; if (pll_to_o !== (k >= 1040)) begin bad++; $display("FAIL to_flag k=%0d got=%b exp=%b", k, pll_to_o, (k >= 1040)); end
      total++; if (rst_n_o !== exp_mask(k, 1048)) begin bad++; $display("FAIL to_mask k=%0d got=%b exp=%b", k, rst_n_o, exp_mask(k, 1048)); end
      total++; if (busy_o !== (k < 1096)) begin bad++; $display("FAIL to_busy k=%0d got=%b exp=%b", k, busy_o, (k < 1096)); end
    end
    total++; if (pll_strb_o !== 1'b0) begin bad++; $display("FAIL to_strb got=%b exp=0", pll_strb_o); end
  endtask

  task automatic test_pll_lock();
    pll_en_i = 1'b1; pll_lock_i = 1'b0;
    apply_reset();
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 16) begin
        total++; if (dbg_state_o !== PLL_WAIT) begin bad++; $display("FAIL lock_wait_state got=%0d exp=%0d", dbg_state_o, PLL_WAIT); end
      end
      total++; if (pll_strb_o !== (k >= 41)) begin bad++; $display("FAIL lock_strb k=%0d got=%b exp=%b", k, pll_strb_o, (k >= 41)); end
      total++; if (rst_n_o !== exp_mask(k, 49)) begin bad++; $display("FAIL lock_mask k=%0d got=%b exp=%b", k, rst_n_o, exp_mask(k, 49)); end
      total++; if (busy_o !== (k < 97)) begin bad++; $display("FAIL lock_busy k=%0d got=%b exp=%b", k, busy_o, (k < 97)); end
      if (k == 39) pll_lock_i = 1'b1;
    end
    total++; if (pll_to_o !== 1'b0) begin bad++; $display("FAIL lock_to got=%b exp=0", pll_to_o); end
  endtask

  task automatic test_pll_loss();
    pll_lock_i = 1'b0;
    tick();
    pll_lock_i = 1'b1;
    repeat (3) tick();
    total++; if (rst_n_o !== 7'h7f) begin bad++; $display("FAIL glitch_mask got=%b exp=%b", rst_n_o, 7'h7f); end
    total++; if (pll_strb_o !== 1'b1) begin bad++; $display("FAIL glitch_strb got=%b exp=1", pll_strb_o); end
    total++; if (rst_cause_o !== 2'b00) begin bad++; $display("FAIL glitch_cause got=%b exp=00", rst_cause_o); end
    pll_lock_i = 1'b0;
    tick();
    total++; if (rst_n_o !== 7'h7f) begin bad++; $display("FAIL loss1_mask got=%b exp=%b", rst_n_o, 7'h7f); end
    pll_en_i = 1'b0;
    tick();
    total++; if (rst_n_o !== 7'h00) begin bad++; $display("FAIL loss2_mask got=%b exp=%b", rst_n_o, 7'h00); end
    total++; if (pll_strb_o !== 1'b0) begin bad++; $display("FAIL loss2_strb got=%b exp=0", pll_strb_o); end
    total++; if (rst_cause_o !== 2'b11) begin bad++; $display("FAIL loss2_cause got=%b exp=11", rst_cause_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL loss2_busy got=%b exp=1", busy_o); end
    for (int k = 1; k <= 75; k++) begin
      tick();
      total++; if (rst_n_o !== exp_mask(k, 24)) begin bad++; $display("FAIL reseq_mask k=%0d got=%b exp=%b", k, rst_n_o, exp_mask(k, 24)); end
    end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reseq_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_wdt_pulse();
    wdt_rst_n_i = 1'b0;
    tick();
    wdt_rst_n_i = 1'b1;
    total++; if (rst_n_o !== 7'h00) begin bad++; $display("FAIL wdt_mask got=%b exp=%b", rst_n_o, 7'h00); end
    total++; if (rst_cause_o !== 2'b10) begin bad++; $display("FAIL wdt_cause got=%b exp=10", rst_cause_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL wdt_busy got=%b exp=1", busy_o); end
    repeat (9) tick();
    wdt_rst_n_i = 1'b0;
    tick();
    wdt_rst_n_i = 1'b1;
    total++; if (dbg_state_o !== HOLD) begin bad++; $display("FAIL wdt_rehold_state got=%0d exp=%0d", dbg_state_o, HOLD); end
    for (int k = 1; k <= 75; k++) begin
      tick();
      total++; if (rst_n_o !== exp_mask(k, 24)) begin bad++; $display("FAIL wdt_reseq_mask k=%0d got=%b exp=%b", k, rst_n_o, exp_mask(k, 24)); end
      total++; if (busy_o !== (k < 72)) begin bad++; $display("FAIL wdt_reseq_busy k=%0d got=%b exp=%b", k, busy_o, (k < 72)); end
    end
  endtask

  task automatic test_back_to_back();
    wdt_rst_n_i = 1'b0;
    tick();
    wdt_rst_n_i = 1'b1;
    for (int k = 1; k <= 43; k++) tick();
    total++; if (rst_n_o !== 7'b1011000) begin bad++; $display("FAIL mid_mask got=%b exp=%b", rst_n_o, 7'b1011000); end
    total++; if (dbg_state_o !== RELEASE) begin bad++; $display("FAIL mid_state got=%0d exp=%0d", dbg_state_o, RELEASE); end
    ext_rst_n_i = 1'b0; wdt_rst_n_i = 1'b0;
    tick();
    total++; if (rst_n_o !== 7'h00) begin bad++; $display("FAIL both_mask got=%b exp=%b", rst_n_o, 7'h00); end
    total++; if (rst_cause_o !== 2'b01) begin bad++; $display("FAIL both_cause got=%b exp=01", rst_cause_o); end
    ext_rst_n_i = 1'b1;
    tick();
    total++; if (rst_cause_o !== 2'b01) begin bad++; $display("FAIL held_cause got=%b exp=01", rst_cause_o); end
    wdt_rst_n_i = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      tick();
      total++; if (rst_n_o !== exp_mask(k, 24)) begin bad++; $display("FAIL both_reseq_mask k=%0d got=%b exp=%b", k, rst_n_o, exp_mask(k, 24)); end
    end
    total++; if (dbg_state_o !== RUN) begin bad++; $display("FAIL both_final_state got=%0d exp=%0d", dbg_state_o, RUN); end
  endtask

  initial begin
    test_reset();
    test_por_bypass();
    test_pll_timeout();
    test_pll_lock();
    test_pll_loss();
    test_wdt_pulse();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
